// File: rtl/rv32_decode_exec_ctrl.sv
// RV32I instruction decoder, integer ALU and the multi-cycle sequencer
// (FETCH / WAIT_INST / DECODE / EXEC / MEM) that drives every datapath select.
module rv32_decode_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        data_valid,
    input  logic [31:0] alu_din1,
    input  logic [31:0] alu_din2,
    output logic [31:0] imm,
    output logic [3:0]  funct,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [3:0]  inst_type,
    output logic [31:0] alu_dout,
    output logic [2:0]  alu_comp,
    output logic        inst_fetch,
    output logic        rd_en,
    output logic        rs1_en,
    output logic        rs2_en,
    output logic [1:0]  rd_din_sel,
    output logic [1:0]  pc_next_sel,
    output logic        alu_din1_sel,
    output logic [1:0]  alu_din2_sel,
    output logic [3:0]  alu_op,
    output logic        store_data,
    output logic        load_data
);
    typedef enum logic [3:0] {
        T_INVALID = 4'd0, T_LUI = 4'd1, T_AUIPC = 4'd2, T_JAL = 4'd3, T_JALR = 4'd4,
        T_BRANCH = 4'd5, T_LOAD = 4'd6, T_STORE = 4'd7, T_OPIMM = 4'd8, T_OP = 4'd9,
        T_SYS = 4'd10
    } inst_type_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_INST, S_DECODE, S_EXEC, S_MEM
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9;
    localparam logic [1:0] RD_NONE = 2'd0, RD_IMM = 2'd1, RD_ALU = 2'd2, RD_MEM = 2'd3;
    localparam logic [1:0] PC_STALL = 2'd0, PC_INCR = 2'd1, PC_ADD_IMM = 2'd2,
                           PC_ADD_RS1_IMM = 2'd3;
    localparam logic [1:0] D2_RS2 = 2'd1, D2_IMM = 2'd2, D2_CONST_4 = 2'd3;

    inst_type_e itype;
    state_e     state_q, state_d;
    logic [2:0] funct3;
    logic       comp_eq, comp_lt, comp_ltu;
    logic       branch_taken;
    logic [3:0] exec_op;

    assign funct3    = inst[14:12];
    assign rd        = inst[11:7];
    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign inst_type = itype;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        itype = T_INVALID;
        case (inst[6:0])
            7'b0110111: itype = T_LUI;
            7'b0010111: itype = T_AUIPC;
            7'b1101111: itype = T_JAL;
            7'b1100111: itype = T_JALR;
            7'b1100011: itype = T_BRANCH;
            7'b0000011: itype = T_LOAD;
            7'b0100011: itype = T_STORE;
            7'b0010011: itype = T_OPIMM;
            7'b0110011: itype = T_OP;
            7'b0001111, 7'b1110011: itype = T_SYS;
            default: itype = T_INVALID;
        endcase
    end

    always_comb begin
        imm = '0;
        case (itype)
            T_JALR, T_LOAD, T_OPIMM: imm = {{20{inst[31]}}, inst[31:20]};
            T_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            T_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            T_LUI, T_AUIPC: imm = {inst[31:12], 12'b0};
            T_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:  imm = '0;
        endcase
    end

    // bit30 distinguishes SUB/SRA; for immediates it is only an opcode bit on shifts right.
    always_comb begin
        funct = {1'b0, funct3};
        if (itype == T_OP || (itype == T_OPIMM && funct3 == 3'b101))
            funct[3] = inst[30];
    end

    assign comp_eq  = (alu_din1 == alu_din2);
    assign comp_lt  = ($signed(alu_din1) < $signed(alu_din2));
    assign comp_ltu = (alu_din1 < alu_din2);
    assign alu_comp = {comp_eq, comp_lt, comp_ltu};

    always_comb begin
        alu_dout = '0;
        case (alu_op)
            OP_ADD:  alu_dout = alu_din1 + alu_din2;
            OP_SUB:  alu_dout = alu_din1 - alu_din2;
            OP_SLL:  alu_dout = alu_din1 << alu_din2[4:0];
            OP_SLT:  alu_dout = {31'b0, comp_lt};
            OP_SLTU: alu_dout = {31'b0, comp_ltu};
            OP_XOR:  alu_dout = alu_din1 ^ alu_din2;
            OP_SRL:  alu_dout = alu_din1 >> alu_din2[4:0];
            OP_SRA:  alu_dout = $unsigned($signed(alu_din1) >>> alu_din2[4:0]);
            OP_OR:   alu_dout = alu_din1 | alu_din2;
            OP_AND:  alu_dout = alu_din1 & alu_din2;
            default: alu_dout = '0;
        endcase
    end

    always_comb begin
        exec_op = OP_ADD;
        case (funct[2:0])
            3'b000:  exec_op = funct[3] ? OP_SUB : OP_ADD;
            3'b001:  exec_op = OP_SLL;
            3'b010:  exec_op = OP_SLT;
            3'b011:  exec_op = OP_SLTU;
            3'b100:  exec_op = OP_XOR;
            3'b101:  exec_op = funct[3] ? OP_SRA : OP_SRL;
            3'b110:  exec_op = OP_OR;
            default: exec_op = OP_AND;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = comp_eq;
            3'b001:  branch_taken = !comp_eq;
            3'b100:  branch_taken = comp_lt;
            3'b101:  branch_taken = !comp_lt;
            3'b110:  branch_taken = comp_ltu;
            3'b111:  branch_taken = !comp_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        inst_fetch   = 1'b0;
        rs1_en       = 1'b0;
        rs2_en       = 1'b0;
        rd_din_sel   = RD_NONE;
        pc_next_sel  = PC_STALL;
        alu_din1_sel = 1'b0;
        alu_din2_sel = 2'd0;
        alu_op       = OP_ADD;
        store_data   = 1'b0;
        load_data    = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                inst_fetch = 1'b1;
                state_d    = S_WAIT_INST;
            end
            S_WAIT_INST: if (inst_valid) state_d = S_DECODE;
            S_DECODE: begin
                rs1_en  = itype inside {T_JALR, T_BRANCH, T_LOAD, T_STORE, T_OPIMM, T_OP};
                rs2_en  = itype inside {T_BRANCH, T_STORE, T_OP};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (itype)
                    T_LUI: begin
                        rd_din_sel = RD_IMM; pc_next_sel = PC_INCR;
                    end
                    T_AUIPC: begin
                        alu_din1_sel = 1'b1; alu_din2_sel = D2_IMM;
                        rd_din_sel = RD_ALU; pc_next_sel = PC_INCR;
                    end
                    T_JAL, T_JALR: begin
                        alu_din1_sel = 1'b1; alu_din2_sel = D2_CONST_4; rd_din_sel = RD_ALU;
                        pc_next_sel = (itype == T_JAL) ? PC_ADD_IMM : PC_ADD_RS1_IMM;
                    end
                    T_BRANCH: begin
                        alu_din2_sel = D2_RS2;
                        pc_next_sel  = branch_taken ? PC_ADD_IMM : PC_INCR;
                    end
                    T_LOAD, T_STORE: begin
                        alu_din2_sel = D2_IMM;
                        load_data    = (itype == T_LOAD);
                        store_data   = (itype == T_STORE);
                        state_d      = S_MEM;
                    end
                    T_OPIMM, T_OP: begin
                        alu_din2_sel = (itype == T_OP) ? D2_RS2 : D2_IMM;
                        alu_op = exec_op; rd_din_sel = RD_ALU; pc_next_sel = PC_INCR;
                    end
                    default: pc_next_sel = PC_INCR;
                endcase
            end
            S_MEM: if (data_valid) begin
                if (itype == T_LOAD) rd_din_sel = RD_MEM;
                pc_next_sel = PC_INCR;
                state_d     = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en = (rd_din_sel != RD_NONE);
endmodule

// File: tb/tb_rv32_decode_exec_ctrl.sv
// Self-checking bench: directed and random instructions walked through the
// sequencer, compared against a behavioural model of the RV32I rules.
module tb_rv32_decode_exec_ctrl;
    typedef struct packed {
        logic       inst_fetch;
        logic       rd_en;
        logic       rs1_en;
        logic       rs2_en;
        logic [1:0] rd_din_sel;
        logic [1:0] pc_next_sel;
        logic       alu_din1_sel;
        logic [1:0] alu_din2_sel;
        logic [3:0] alu_op;
        logic       store_data;
        logic       load_data;
    } ctrl_t;

    localparam logic [3:0] F3_BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [6:0] OPCODES [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
        7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};

    logic        clk = 1'b0;
    logic        rst, inst_valid, data_valid;
    logic [31:0] inst, alu_din1, alu_din2;
    logic [31:0] imm, alu_dout;
    logic [3:0]  funct, inst_type, alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  alu_comp;
    logic        inst_fetch, rd_en, rs1_en, rs2_en, alu_din1_sel, store_data, load_data;
    logic [1:0]  rd_din_sel, pc_next_sel, alu_din2_sel;
    ctrl_t       obs;
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    rv32_decode_exec_ctrl dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .data_valid(data_valid),
        .alu_din1(alu_din1), .alu_din2(alu_din2), .imm(imm), .funct(funct), .rd(rd),
        .rs1(rs1), .rs2(rs2), .inst_type(inst_type), .alu_dout(alu_dout), .alu_comp(alu_comp),
        .inst_fetch(inst_fetch), .rd_en(rd_en), .rs1_en(rs1_en), .rs2_en(rs2_en),
        .rd_din_sel(rd_din_sel), .pc_next_sel(pc_next_sel), .alu_din1_sel(alu_din1_sel),
        .alu_din2_sel(alu_din2_sel), .alu_op(alu_op), .store_data(store_data),
        .load_data(load_data)
    );

    assign obs = {inst_fetch, rd_en, rs1_en, rs2_en, rd_din_sel, pc_next_sel, alu_din1_sel,
                  alu_din2_sel, alu_op, store_data, load_data};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, want);
    endtask

    task automatic chk_ctrl(input string tag, input ctrl_t want);
        chk(tag, {15'b0, obs}, {15'b0, want});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] cls_of(input logic [31:0] i);
        case (i[6:0])
            7'b0110111: return 4'd1;
            7'b0010111: return 4'd2;
            7'b1101111: return 4'd3;
            7'b1100111: return 4'd4;
            7'b1100011: return 4'd5;
            7'b0000011: return 4'd6;
            7'b0100011: return 4'd7;
            7'b0010011: return 4'd8;
            7'b0110011: return 4'd9;
            7'b0001111, 7'b1110011: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] imm_ref(input logic [31:0] i);
        case (cls_of(i))
            4'd4, 4'd6, 4'd8: return 32'($signed(i[31:20]));
            4'd7: return 32'($signed({i[31:25], i[11:7]}));
            4'd5: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            4'd1, 4'd2: return {i[31:12], 12'b0};
            4'd3: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic q30(input logic [31:0] i);
        return i[30] && (cls_of(i) == 4'd9 || (cls_of(i) == 4'd8 && i[14:12] == 3'd5));
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t exec_ref(input logic [31:0] i, input logic [31:0] a,
                                       input logic [31:0] b);
        ctrl_t c;
        logic [2:0] f3;
        c  = '0;
        f3 = i[14:12];
        case (cls_of(i))
            4'd1: begin c.rd_din_sel = 2'd1; c.pc_next_sel = 2'd1; end
            4'd2: begin c.alu_din1_sel = 1'b1; c.alu_din2_sel = 2'd2; c.rd_din_sel = 2'd2;
                        c.pc_next_sel = 2'd1; end
            4'd3: begin c.alu_din1_sel = 1'b1; c.alu_din2_sel = 2'd3; c.rd_din_sel = 2'd2;
                        c.pc_next_sel = 2'd2; end
            4'd4: begin c.alu_din1_sel = 1'b1; c.alu_din2_sel = 2'd3; c.rd_din_sel = 2'd2;
                        c.pc_next_sel = 2'd3; end
            4'd5: begin c.alu_din2_sel = 2'd1;
                        c.pc_next_sel = taken_ref(f3, a, b) ? 2'd2 : 2'd1; end
            4'd6: begin c.alu_din2_sel = 2'd2; c.load_data = 1'b1; end
            4'd7: begin c.alu_din2_sel = 2'd2; c.store_data = 1'b1; end
            4'd8, 4'd9: begin
                c.alu_din2_sel = (cls_of(i) == 4'd9) ? 2'd1 : 2'd2;
                c.rd_din_sel   = 2'd2;
                c.pc_next_sel  = 2'd1;
                c.alu_op = F3_BASE[f3] + ((q30(i) && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
            end
            default: c.pc_next_sel = 2'd1;
        endcase
        c.rd_en = (c.rd_din_sel != 2'd0);
        return c;
    endfunction

    // Walk one instruction from FETCH back to the next FETCH, checking every cycle.
    task automatic run_inst(input string tag, input logic [31:0] i, input logic [31:0] a,
                            input logic [31:0] b, input int waits, input int mem_wait,
                            input bit abort_in_mem);
        ctrl_t      e;
        logic [3:0] cls;
        cls = cls_of(i);
        e = '0; e.inst_fetch = 1'b1;
        chk_ctrl({tag, ".fetch"}, e);
        tick();
        for (int k = 0; k < waits - 1; k++) begin
            data_valid = (k == 0);
            #1 chk_ctrl({tag, ".wait"}, '0);
            tick();
            data_valid = 1'b0;
        end
        inst = i; inst_valid = 1'b1;
        #1 chk_ctrl({tag, ".wait_v"}, '0);
        tick();
        inst_valid = 1'b0; alu_din1 = a; alu_din2 = b;
        #1;
        e = '0;
        e.rs1_en = cls inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        e.rs2_en = cls inside {4'd5, 4'd7, 4'd9};
        chk_ctrl({tag, ".decode"}, e);
        chk({tag, ".type"}, {28'b0, inst_type}, {28'b0, cls});
        chk({tag, ".imm"}, imm, imm_ref(i));
        chk({tag, ".funct"}, {28'b0, funct}, {28'b0, q30(i), i[14:12]});
        chk({tag, ".regs"}, {17'b0, rd, rs1, rs2}, {17'b0, i[11:7], i[19:15], i[24:20]});
        tick();
        e = exec_ref(i, a, b);
        chk_ctrl({tag, ".exec"}, e);
        chk({tag, ".alu"}, alu_dout, alu_ref(e.alu_op, a, b));
        chk({tag, ".comp"}, {29'b0, alu_comp},
            {29'b0, a == b, $signed(a) < $signed(b), a < b});
        tick();
        if (cls == 4'd6 || cls == 4'd7) begin
            for (int k = 0; k < mem_wait; k++) begin
                #1 chk_ctrl({tag, ".mem_stall"}, '0);
                tick();
            end
            if (abort_in_mem) begin
                rst = 1'b1; data_valid = 1'b1;
                #1 chk_ctrl({tag, ".rst_in_mem"}, '0);
                tick();
                chk_ctrl({tag, ".rst_held"}, '0);
                tick();
                data_valid = 1'b0; rst = 1'b0;
                #1 chk_ctrl({tag, ".idle"}, '0);
                tick();
                return;
            end
            data_valid = 1'b1;
            e = '0; e.pc_next_sel = 2'd1;
            if (cls == 4'd6) begin e.rd_din_sel = 2'd3; e.rd_en = 1'b1; end
            #1 chk_ctrl({tag, ".mem_done"}, e);
            tick();
            data_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a, b, i;
        rst = 1'b1; inst = '0; inst_valid = 1'b0; data_valid = 1'b0;
        alu_din1 = '0; alu_din2 = '0;
        tick(); tick();
        chk_ctrl("reset_held", '0);
        rst = 1'b0;
        #1 chk_ctrl("idle_after_reset", '0);
        tick();

        run_inst("addi",  32'hFFB00093, 32'h0, 32'hFFFFFFFB, 1, 0, 1'b0);
        run_inst("sra",   32'h407352B3, 32'h80000000, 32'h4, 2, 0, 1'b0);
        run_inst("sltu",  32'h007332B3, 32'h1, 32'hFFFFFFFF, 1, 0, 1'b0);
        run_inst("add55", 32'h007302B3, 32'h5, 32'h5, 1, 0, 1'b0);
        run_inst("bne_eq", 32'h00209463, 32'h77, 32'h77, 1, 0, 1'b0);
        run_inst("bne_ne", 32'h00209463, 32'h77, 32'h78, 3, 0, 1'b0);
        run_inst("lw",    32'h0040A183, 32'h100, 32'h4, 1, 3, 1'b0);
        run_inst("lw_rst", 32'h0040A183, 32'h100, 32'h4, 1, 1, 1'b1);

        for (int n = 0; n < 150; n++) begin
            int idx;
            r   = $urandom();
            idx = $urandom_range(0, 11);
            i   = {r[31:7], (idx == 11) ? r[6:0] : OPCODES[idx]};
            a   = $urandom();
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
            run_inst($sformatf("rnd%0d", n), i, a, b, $urandom_range(1, 3),
                     $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
